// File: rtl/sa_cache_ctrl_if.sv
// CPU load port, memory fill port, flush and statistics for sa_cache_ctrl.
// The cache connects through the slave modport; the CPU/memory side uses master.
interface sa_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int OFF_W  = 2,
    parameter int CNT_W  = 16
) ();
    localparam int LINE_W = WORD_W << OFF_W;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_rsp_valid;
    logic [WORD_W-1:0] cpu_rsp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              flush;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport slave (
        input  cpu_req_valid, cpu_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_addr,
               hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req_valid, cpu_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, flush,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_addr,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/sa_cache_ctrl.sv
// Read-only 2-way set-associative cache with LRU replacement, single-beat line
// refill, whole-cache flush and saturating hit/miss counters.
module sa_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int OFF_W  = 2,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    sa_cache_ctrl_if.slave   bus
);
    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;
    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [SETS-1:0][1:0]    valid_q;
    logic [SETS-1:0]         lru_q;
    logic [WORD_W-1:0]       rsp_data_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [CNT_W-1:0]        hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]        tag_mem  [2][SETS];
    line_t                   data_mem [2][SETS];

    logic [TAG_W-1:0]        tag;
    logic [IDX_W-1:0]        idx;
    logic [OFF_W-1:0]        off;
    logic                    hit0, hit1, hit, hit_way, victim, fill;
    line_t                   fill_line;

    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign idx       = addr_q[OFF_W +: IDX_W];
    assign off       = addr_q[OFF_W-1:0];
    assign fill_line = bus.mem_rsp_data;

    assign hit0    = valid_q[idx][0] && (tag_mem[0][idx] == tag);
    assign hit1    = valid_q[idx][1] && (tag_mem[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;
    assign victim  = !valid_q[idx][0] ? 1'b0 : (!valid_q[idx][1] ? 1'b1 : lru_q[idx]);
    assign fill    = (state_q == MEM_WAIT) && bus.mem_rsp_valid;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latches).
        state_d           = state_q;
        bus.cpu_req_ready = 1'b0;
        bus.cpu_rsp_valid = 1'b0;
        bus.mem_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (!bus.flush && bus.cpu_req_valid) state_d = LOOKUP;
            end
            LOOKUP:   state_d = hit ? RESPOND : MEM_REQ;
            MEM_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: if (bus.mem_rsp_valid) state_d = RESPOND;
            RESPOND: begin
                bus.cpu_rsp_valid = 1'b1;
                state_d           = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
            rsp_data_q <= '0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.flush) valid_q <= '0;
                    else if (bus.cpu_req_valid) addr_q <= bus.cpu_addr;
                end
                LOOKUP: begin
                    if (hit) begin
                        lru_q[idx] <= ~hit_way;
                        rsp_data_q <= data_mem[hit_way][idx][off];
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                    end else begin
                        mem_addr_q <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        valid_q[idx][victim] <= 1'b1;
                        lru_q[idx]           <= ~victim;
                        rsp_data_q           <= fill_line[off];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[victim][idx]  <= tag;
            data_mem[victim][idx] <= fill_line;
        end
    end

    assign bus.cpu_rsp_data = rsp_data_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.hit_cnt      = hit_cnt_q;
    assign bus.miss_cnt     = miss_cnt_q;
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Self-checking bench for sa_cache_ctrl: directed scenarios followed by random
// reads, compared against a recency-queue model of a 2-way LRU cache.
module tb_sa_cache_ctrl;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 2;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 4;
    localparam int SETS   = 1 << IDX_W;
    localparam int LINE_W = WORD_W << OFF_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_cache_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

    sa_cache_ctrl #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFF_W(OFF_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per set, resident tags ordered least- to most-recently used.
    int unsigned recency [SETS][$];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mem_word(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] base;
        base = addr & ~32'h3;
        if (base == 32'h10) return 32'hA + WORD_W'(addr[1:0]);
        return (addr * 32'h0001_0003) ^ 32'h5A00_0000;
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] addr);
        logic [LINE_W-1:0] l;
        logic [ADDR_W-1:0] base;
        base = addr & ~32'h3;
        l = '0;
        for (int k = 0; k < 4; k++) l[k*WORD_W +: WORD_W] = mem_word(base + 32'(k));
        return l;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) recency[s].delete();
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < SETS; s++) recency[s].delete();
    endfunction

    function automatic bit model_access(input logic [ADDR_W-1:0] addr);
        int          s;
        int unsigned t;
        s = int'(addr[OFF_W +: IDX_W]);
        t = addr >> (OFF_W + IDX_W);
        for (int i = 0; i < recency[s].size(); i++) begin
            if (recency[s][i] == t) begin
                recency[s].delete(i);
                recency[s].push_back(t);
                if (exp_hits < CMAX) exp_hits++;
                return 1'b1;
            end
        end
        if (recency[s].size() == 2) void'(recency[s].pop_front());
        recency[s].push_back(t);
        if (exp_misses < CMAX) exp_misses++;
        return 1'b0;
    endfunction

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int stall);
        bit                exp_hit;
        bit                saw_mem;
        bit                got;
        int                cyc;
        int                rsp_cyc;
        logic [ADDR_W-1:0] line_addr;
        exp_hit   = model_access(addr);
        line_addr = addr & ~32'h3;
        saw_mem   = 1'b0;
        got       = 1'b0;
        rsp_cyc   = 0;
        @(negedge clk);
        chk("req_ready_idle", bus.cpu_req_ready, 1'b1);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = addr;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr      = $urandom;
        cyc = 1;
        while (!got && cyc < 200) begin
            if (bus.mem_req_valid) begin
                saw_mem = 1'b1;
                chk("mem_addr", bus.mem_addr, line_addr);
                for (int s = 0; s < stall; s++) begin
                    chk("stall_req_valid", bus.mem_req_valid, 1'b1);
                    chk("stall_mem_addr", bus.mem_addr, line_addr);
                    chk("stall_req_ready", bus.cpu_req_ready, 1'b0);
                    @(negedge clk);
                    cyc++;
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                chk("mem_req_dropped", bus.mem_req_valid, 1'b0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = mem_line(addr);
                @(negedge clk);
                bus.mem_rsp_valid = 1'b0;
                bus.mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
                cyc += 3;
            end
            if (bus.cpu_rsp_valid) begin
                got     = 1'b1;
                rsp_cyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("rsp_seen", got, 1'b1);
        chk("mem_req_iff_miss", saw_mem, !exp_hit);
        chk("rsp_data", bus.cpu_rsp_data, mem_word(addr));
        if (exp_hit) chk("hit_latency", 64'(rsp_cyc), 64'd2);
        @(negedge clk);
        chk("rsp_one_cycle", bus.cpu_rsp_valid, 1'b0);
        chk("rsp_data_hold", bus.cpu_rsp_data, mem_word(addr));
        chk("hit_cnt", bus.hit_cnt, 64'(exp_hits));
        chk("miss_cnt", bus.miss_cnt, 64'(exp_misses));
    endtask

    task automatic do_flush(input bit with_req, input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        bus.flush         = 1'b1;
        bus.cpu_req_valid = with_req;
        bus.cpu_addr      = addr;
        @(negedge clk);
        bus.flush         = 1'b0;
        bus.cpu_req_valid = 1'b0;
        chk("flush_no_accept", bus.cpu_req_ready, 1'b1);
        chk("flush_no_mem_req", bus.mem_req_valid, 1'b0);
        model_flush();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, bus.cpu_rsp_valid, 1'b0);
        chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
        chk({tag, "_rsp_data"}, bus.cpu_rsp_data, '0);
        chk({tag, "_mem_addr"}, bus.mem_addr, '0);
        chk({tag, "_hit_cnt"}, bus.hit_cnt, '0);
        chk({tag, "_miss_cnt"}, bus.miss_cnt, '0);
        chk({tag, "_req_ready"}, bus.cpu_req_ready, 1'b1);
    endtask

    initial begin
        int k;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.flush         = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Cold miss, then a hit on the freshly filled line
        do_read(32'h10, 0);
        do_read(32'h12, 0);

        // LRU in set 0: 0x00 and 0x10 resident, touch 0x00, 0x20 evicts 0x10
        do_read(32'h00, 1);
        do_read(32'h01, 0);
        do_read(32'h20, 0);
        do_read(32'h03, 0);
        do_read(32'h11, 0);

        // Memory holds off the request for five cycles
        do_read(32'h35, 5);

        // Flush wins over a simultaneous request; then 0x12 misses
        do_flush(1'b1, 32'h12);
        repeat (2) begin
            @(negedge clk);
            chk("flush_stays_idle", bus.cpu_req_ready, 1'b1);
        end
        do_read(32'h12, 0);

        // Reset in the middle of a refill
        @(negedge clk);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = 32'h44;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        k = 0;
        while (!bus.mem_req_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_mem_req", bus.mem_req_valid, 1'b1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midmiss_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_line(32'h44);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        repeat (2) begin
            chk("late_fill_ignored", bus.cpu_rsp_valid, 1'b0);
            chk("late_fill_idle", bus.cpu_req_ready, 1'b1);
            @(negedge clk);
        end
        do_read(32'h44, 1);

        // Random traffic over three tags per set, with occasional flushes
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) do_flush(1'($urandom_range(0, 1)), 32'($urandom_range(0, 47)));
            else do_read(32'($urandom_range(0, 47)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
